// File: rtl/hyperbus_arb_pkg.sv
// Shared types and helpers for the hyperbus request-port arbiter.
// The state encoding is one-hot so each state decodes from a single flop.
package hyperbus_arb_pkg;

  localparam int MAX_NREQ = 8;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    ISSUE   = 5'b00010,
    WAIT_WR = 5'b00100,
    WAIT_RD = 5'b01000,
    DONE    = 5'b10000
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces both a one-hot grant and the matching binary index.
module hyperbus_rr_arbiter
  import hyperbus_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]              req,
  input  logic [idx_width(NREQ)-1:0]   ptr,
  output logic [NREQ-1:0]              grant,
  output logic [idx_width(NREQ)-1:0]   idx,
  output logic                         any
);

  localparam int IW = idx_width(NREQ);

  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin sharing of one hyperbus_fifo request port between NREQ masters.
// Optional completion watchdog enabled by defining HYPERBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter
  import hyperbus_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0]              req_we_i,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_adr_i,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_dat_i,
  input  logic [NREQ*DATA_WIDTH/8-1:0] req_sel_i,
  output logic [NREQ-1:0]              ack_o,
  output logic [NREQ-1:0]              err_o,
  output logic [DATA_WIDTH-1:0]        dat_o,
  output logic [NREQ-1:0]              grant_o,
  output logic                         rrq,
  output logic                         wrq,
  output logic [ADDR_WIDTH-1:0]        adr_o,
  output logic [DATA_WIDTH-1:0]        tx_dat_o,
  output logic [DATA_WIDTH/8-1:0]      tx_mask_o,
  input  logic [DATA_WIDTH-1:0]        rx_dat_i,
  input  logic                         tx_ready,
  input  logic                         rx_valid
);

  localparam int IW = idx_width(NREQ);
  localparam int MW = DATA_WIDTH / 8;

  if (NREQ < 2 || NREQ > MAX_NREQ || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("hyperbus_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_t            state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         ptr_next;
  logic [IW-1:0]         pick_idx;
  logic [NREQ-1:0]       pick_grant;
  logic                  pick_any;
  logic                  we;
  logic                  done_hit;
  logic [ADDR_WIDTH-1:0] sel_adr;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [MW-1:0]         sel_sel;

  hyperbus_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_adr  = req_adr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_dat  = req_dat_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_sel  = req_sel_i[int'(pick_idx)*MW +: MW];
  assign ptr_next = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  // Only the handshake matching the latched direction can complete a transfer.
  assign done_hit = (state == WAIT_WR) ? tx_ready : rx_valid;

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt;
`else
  assign err_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      we        <= 1'b0;
      grant_o   <= '0;
      ack_o     <= '0;
      rrq       <= 1'b0;
      wrq       <= 1'b0;
      adr_o     <= '0;
      tx_dat_o  <= '0;
      tx_mask_o <= '0;
      dat_o     <= '0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      err_o     <= '0;
      wait_cnt  <= '0;
`endif
    end else begin
      rrq   <= 1'b0;
      wrq   <= 1'b0;
      ack_o <= '0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      err_o <= '0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner     <= pick_idx;
            grant_o   <= pick_grant;
            we        <= req_we_i[pick_idx];
            rrq       <= ~req_we_i[pick_idx];
            wrq       <= req_we_i[pick_idx];
            adr_o     <= sel_adr & ~ADDR_WIDTH'(3);
            tx_dat_o  <= sel_dat;
            tx_mask_o <= ~sel_sel;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= we ? WAIT_WR : WAIT_RD;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT_WR, WAIT_RD: begin
          if (done_hit) begin
            if (state == WAIT_RD) dat_o <= rx_dat_i;
            ack_o <= grant_o;
            state <= DONE;
          end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            err_o   <= grant_o;
            dat_o   <= '0;
            grant_o <= '0;
            ptr     <= ptr_next;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          ptr     <= ptr_next;
          grant_o <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
